// File: rtl/msg_framer_pkg.sv
// Shared constants, state encoding and helpers for the message framer family.
package msg_framer_pkg;

  localparam int unsigned LEN_W = 16;

  localparam logic [7:0] MARKER_MASTER             = 8'hA5;
  localparam logic [7:0] FLAG_CONTROL_COMMAND_WORD = 8'h01;
  localparam logic [7:0] FLAG_STATUS_WORD          = 8'h02;
  localparam logic [7:0] FLAG_DATA_BLOCK           = 8'h03;
  localparam logic [7:0] FLAG_EVENT_REPORT         = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MARK    = 3'd1,
    ST_FLAG    = 3'd2,
    ST_N1      = 3'd3,
    ST_N2      = 3'd4,
    ST_PAYLOAD = 3'd5,
    ST_CSUM    = 3'd6
  } state_t;

  // Index of the set bit in a one-hot vector of up to eight channels.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/msg_framer_if.sv
// Source-side and coder-side handshake bundle of the message framer.
interface msg_framer_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LEN_W  = 16
);
  logic [NUM_CH-1:0]       ch_req;
  logic [NUM_CH*LEN_W-1:0] ch_len;
  logic [NUM_CH*8-1:0]     ch_data;
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH-1:0]       ch_ready;
  logic [NUM_CH-1:0]       ch_grant;
  logic [7:0]              out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic                    msg_end;

  modport master (
    input  ch_req, ch_len, ch_data, ch_valid, out_ready,
    output ch_ready, ch_grant, out_data, out_valid, busy, msg_end
  );

  modport slave (
    output ch_req, ch_len, ch_data, ch_valid, out_ready,
    input  ch_ready, ch_grant, out_data, out_valid, busy, msg_end
  );
endinterface

// File: rtl/msg_framer_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer, cyclically.
module msg_framer_rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grant
);
  localparam int unsigned W2 = 2 * NUM_CH;

  logic [NUM_CH-1:0] w_rot;
  logic [W2-1:0]     w_pick;
  logic [W2-1:0]     w_grant2;

  // Rotate so the pointer lands on bit 0, pick lowest, rotate back.
  always_comb begin
    w_rot  = NUM_CH'({i_req, i_req} >> i_ptr);
    w_pick = '0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (w_rot[k]) w_pick = W2'(1) << k;
    end
    w_grant2 = w_pick << i_ptr;
    o_grant  = w_grant2[NUM_CH-1:0] | w_grant2[W2-1:NUM_CH];
  end
endmodule

// File: rtl/msg_framer.sv
// Multi-source framer: arbitrates channels and emits MARKER/FLAG/N1/N2/payload/CSUM.
module msg_framer
  import msg_framer_pkg::*;
#(
  parameter int unsigned          NUM_CH     = 4,
  parameter int unsigned          LEN_W      = 16,
  parameter logic [7:0]           MARKER     = MARKER_MASTER,
  parameter logic [NUM_CH*8-1:0]  FLAG_TABLE = {FLAG_EVENT_REPORT, FLAG_DATA_BLOCK,
                                                FLAG_STATUS_WORD, FLAG_CONTROL_COMMAND_WORD},
  parameter bit                   CSUM_EN    = 1'b1
) (
  input logic               clk,
  input logic               rst,
  msg_framer_if.master      mif
);
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_sel, r_rr_ptr;
  logic [NUM_CH-1:0] r_grant;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic [7:0]        r_csum;

  logic [NUM_CH-1:0] w_arb_grant, w_ch_ready;
  logic [IDX_W-1:0]  w_arb_idx;
  logic [LEN_W-1:0]  w_arb_len;
  logic [7:0]        w_sel_data, w_sel_flag, w_out_data;
  logic              w_sel_valid, w_out_valid, w_xfer, w_last, w_take, w_pay_last;

  msg_framer_rr_arbiter #(.NUM_CH(NUM_CH), .PTR_W(IDX_W)) u_arb (
    .i_req   (mif.ch_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant)
  );

  assign w_arb_idx = IDX_W'(onehot_to_idx(8'(w_arb_grant)));

  // Per-channel muxes for the latched channel and the arbitration winner.
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_flag  = '0;
    w_arb_len   = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (r_sel == IDX_W'(i)) begin
        w_sel_data  = mif.ch_data[i*8 +: 8];
        w_sel_valid = mif.ch_valid[i];
        w_sel_flag  = FLAG_TABLE[i*8 +: 8];
      end
      if (w_arb_idx == IDX_W'(i)) w_arb_len = mif.ch_len[i*LEN_W +: LEN_W];
    end
  end

  // Next-state and output decode; payload is a combinational pass-through.
  always_comb begin
    w_state_nxt = r_state;
    w_out_valid = 1'b0;
    w_out_data  = '0;
    w_ch_ready  = '0;
    w_take      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE:    w_take = |mif.ch_req;
      ST_MARK:    begin w_out_valid = 1'b1; w_out_data = MARKER;       end
      ST_FLAG:    begin w_out_valid = 1'b1; w_out_data = w_sel_flag;   end
      ST_N1:      begin w_out_valid = 1'b1; w_out_data = r_len[15:8];  end
      ST_N2:      begin w_out_valid = 1'b1; w_out_data = r_len[7:0];   end
      ST_PAYLOAD: begin
        w_out_valid = w_sel_valid;
        w_out_data  = w_sel_data;
        w_ch_ready  = r_grant & {NUM_CH{mif.out_ready}};
      end
      ST_CSUM:    begin w_out_valid = 1'b1; w_out_data = r_csum;       end
      default:    ;
    endcase
    w_xfer     = w_out_valid & mif.out_ready;
    w_pay_last = (r_cnt == r_len - LEN_W'(1));
    case (r_state)
      ST_IDLE: if (w_take) w_state_nxt = ST_MARK;
      ST_MARK: if (w_xfer) w_state_nxt = ST_FLAG;
      ST_FLAG: if (w_xfer) w_state_nxt = ST_N1;
      ST_N1:   if (w_xfer) w_state_nxt = ST_N2;
      ST_N2: begin
        if (w_xfer) begin
          if (r_len == '0) begin
            w_state_nxt = CSUM_EN ? ST_CSUM : ST_IDLE;
            w_last      = !CSUM_EN;
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_xfer && w_pay_last) begin
          w_state_nxt = CSUM_EN ? ST_CSUM : ST_IDLE;
          w_last      = !CSUM_EN;
        end
      end
      ST_CSUM: begin
        if (w_xfer) begin
          w_state_nxt = ST_IDLE;
          w_last      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Grant latch, length counter and running checksum (MARKER excluded).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant  <= '0;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_csum   <= '0;
    end else begin
      if (w_take) begin
        r_grant  <= w_arb_grant;
        r_sel    <= w_arb_idx;
        r_len    <= w_arb_len;
        r_rr_ptr <= (w_arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : w_arb_idx + IDX_W'(1);
        r_cnt    <= '0;
        r_csum   <= '0;
      end
      if (w_xfer && (r_state != ST_MARK) && (r_state != ST_CSUM)) r_csum <= r_csum + w_out_data;
      if (w_xfer && (r_state == ST_PAYLOAD)) r_cnt <= r_cnt + LEN_W'(1);
      if (w_xfer && w_last) r_grant <= '0;
    end
  end

  assign mif.ch_grant  = r_grant;
  assign mif.ch_ready  = w_ch_ready;
  assign mif.out_data  = w_out_data;
  assign mif.out_valid = w_out_valid;
  assign mif.busy      = (r_state != ST_IDLE);
  assign mif.msg_end   = w_xfer & w_last & ~rst;

endmodule

// File: tb/tb_msg_framer.sv
// Directed scoreboard bench for msg_framer (checksum and no-checksum builds).
module tb_msg_framer;
  import msg_framer_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned LW  = 16;
  localparam logic [NCH*8-1:0] FT = {FLAG_EVENT_REPORT, FLAG_DATA_BLOCK,
                                     FLAG_STATUS_WORD, FLAG_CONTROL_COMMAND_WORD};

  typedef struct packed { logic [7:0] d; logic last; } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic tgt;
  logic [NCH-1:0]    ch_req, ch_valid;
  logic [NCH*LW-1:0] ch_len;
  logic [NCH*8-1:0]  ch_data;
  logic              out_ready;
  logic [NCH*8-1:0]  ft_v;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msg_framer_if #(.NUM_CH(NCH), .LEN_W(LW)) if1 ();
  msg_framer_if #(.NUM_CH(NCH), .LEN_W(LW)) if0 ();

  assign if1.ch_req    = tgt ? ch_req   : '0;
  assign if1.ch_len    = ch_len;
  assign if1.ch_data   = ch_data;
  assign if1.ch_valid  = tgt ? ch_valid : '0;
  assign if1.out_ready = out_ready;
  assign if0.ch_req    = tgt ? '0 : ch_req;
  assign if0.ch_len    = ch_len;
  assign if0.ch_data   = ch_data;
  assign if0.ch_valid  = tgt ? '0 : ch_valid;
  assign if0.out_ready = out_ready;

  msg_framer #(.NUM_CH(NCH), .LEN_W(LW), .MARKER(MARKER_MASTER), .FLAG_TABLE(FT), .CSUM_EN(1'b1))
    u_dut1 (.clk(clk), .rst(rst), .mif(if1));
  msg_framer #(.NUM_CH(NCH), .LEN_W(LW), .MARKER(MARKER_MASTER), .FLAG_TABLE(FT), .CSUM_EN(1'b0))
    u_dut0 (.clk(clk), .rst(rst), .mif(if0));

  logic [7:0]     m_data;
  logic           m_valid, m_end, m_busy;
  logic [NCH-1:0] m_grant, m_ready;
  assign m_data  = tgt ? if1.out_data  : if0.out_data;
  assign m_valid = tgt ? if1.out_valid : if0.out_valid;
  assign m_end   = tgt ? if1.msg_end   : if0.msg_end;
  assign m_busy  = tgt ? if1.busy      : if0.busy;
  assign m_grant = tgt ? if1.ch_grant  : if0.ch_grant;
  assign m_ready = tgt ? if1.ch_ready  : if0.ch_ready;

  function automatic logic [7:0] pay(input int c, input int k, input bit ff);
    return ff ? 8'hFF : 8'((k + 1) * 16 + c);
  endfunction

  // Output monitor: pops the scoreboard on every accepted byte.
  logic [7:0] hold_d;
  bit         hold = 1'b0;
  exp_t       e;
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      checks++;
      assert ((m_ready & ~m_grant) === '0) else begin
        errors++; $error("FAIL ready_ungranted obs=%b exp=0", m_ready & ~m_grant);
      end
      if (hold && m_valid) begin
        checks++;
        assert (m_data === hold_d) else begin
          errors++; $error("FAIL stall_stable obs=%h exp=%h", m_data, hold_d);
        end
      end
      if (m_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $error("FAIL unexpected_byte obs=%h exp=none", m_data);
        end else begin
          e = sb.pop_front();
          assert (m_data === e.d) else begin
            errors++; $error("FAIL out_data obs=%h exp=%h", m_data, e.d);
          end
          checks++;
          assert (m_end === e.last) else begin
            errors++; $error("FAIL msg_end obs=%b exp=%b byte=%h", m_end, e.last, e.d);
          end
        end
      end else begin
        checks++;
        assert (m_end === 1'b0) else begin
          errors++; $error("FAIL msg_end_idle obs=%b exp=0", m_end);
        end
      end
      hold   = m_valid && !out_ready;
      hold_d = m_data;
    end
  end

  // One frame on channel ch; rst_at>=0 pulses reset after that many payload bytes.
  task automatic do_frame(input int ch, input int len, input bit stall, input logic [NCH-1:0] req,
                          input bit drop_req, input bit ffpat, input int rst_at);
    int idx [NCH];
    logic [NCH-1:0] acc;
    logic [7:0] flag, cs, b;
    logic [15:0] l16;
    bit granted, done, any_ready, drop_pending;
    int cyc, xfers;
    l16 = 16'(len);
    flag = ft_v[ch*8 +: 8];
    granted = 1'b0; done = 1'b0; any_ready = 1'b0; drop_pending = 1'b0;
    cyc = 0; acc = '0;
    for (int c = 0; c < int'(NCH); c++) idx[c] = 0;
    cs = 8'(flag + l16[15:8] + l16[7:0]);
    sb.push_back('{d: MARKER_MASTER, last: 1'b0});
    sb.push_back('{d: flag,        last: 1'b0});
    sb.push_back('{d: l16[15:8],   last: 1'b0});
    sb.push_back('{d: l16[7:0],    last: (len == 0) && !tgt});
    for (int k = 0; k < len; k++) begin
      b  = pay(ch, k, ffpat);
      cs = 8'(cs + b);
      sb.push_back('{d: b, last: (k == len - 1) && !tgt});
    end
    if (tgt) sb.push_back('{d: cs, last: 1'b1});
    ch_len = {NCH{l16}};
    ch_req = req;
    while (!done && cyc < 4000) begin
      if (drop_pending) begin
        ch_req = '0;
        ch_len = '1;
        drop_pending = 1'b0;
      end
      for (int c = 0; c < int'(NCH); c++) begin
        if (acc[c]) begin idx[c]++; ch_valid[c] = 1'b0; end
        if (!ch_valid[c] && idx[c] < len) begin
          ch_valid[c] = stall ? (cyc % 3 != 0) : 1'b1;
          ch_data[c*8 +: 8] = pay(c, idx[c], ffpat);
        end
      end
      if (rst_at >= 0 && granted && idx[ch] == rst_at) begin
        rst = 1'b1; ch_req = '0; ch_valid = '0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        assert ({m_busy, m_valid, m_end, m_grant, m_ready, m_data} === '0) else begin
          errors++; $error("FAIL reset_mid obs=%b exp=0", {m_busy, m_valid, m_end, m_grant, m_ready, m_data});
        end
        sb.delete();
        return;
      end
      out_ready = stall ? 1'(cyc % 2) : 1'b1;
      @(negedge clk);
      if (!granted && m_busy) begin
        granted = 1'b1;
        checks++;
        assert (m_grant === NCH'(1 << ch)) else begin
          errors++; $error("FAIL grant obs=%b exp=%b", m_grant, NCH'(1 << ch));
        end
        if (drop_req) drop_pending = 1'b1;
      end
      acc = m_ready & ch_valid;
      any_ready |= |m_ready;
      if (m_valid && out_ready && m_end) done = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    assert (done) else begin
      errors++; $error("FAIL frame_timeout obs=%0d exp=done", cyc);
    end
    checks++;
    assert (!m_busy && m_grant === '0) else begin
      errors++; $error("FAIL post_idle obs=%b/%b exp=0/0", m_busy, m_grant);
    end
    xfers = idx[ch] + int'(acc[ch]);
    checks++;
    assert (xfers == len) else begin
      errors++; $error("FAIL payload_count obs=%0d exp=%0d", xfers, len);
    end
    if (len == 0) begin
      checks++;
      assert (any_ready === 1'b0) else begin
        errors++; $error("FAIL ready_len0 obs=%b exp=0", any_ready);
      end
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL sb_drain obs=%0d exp=0", sb.size());
    end
    ch_valid = '0;
  endtask

  initial begin
    ft_v = FT;
    rst = 1'b1; tgt = 1'b1;
    ch_req = '0; ch_valid = '0; ch_len = '0; ch_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert ({if1.busy, if1.out_valid, if1.msg_end, if1.ch_grant, if1.ch_ready, if1.out_data} === '0) else begin
      errors++; $error("FAIL reset_dut1 obs=%b exp=0", {if1.busy, if1.out_valid, if1.msg_end, if1.ch_grant, if1.ch_ready, if1.out_data});
    end
    checks++;
    assert ({if0.busy, if0.out_valid, if0.msg_end, if0.ch_grant, if0.ch_ready, if0.out_data} === '0) else begin
      errors++; $error("FAIL reset_dut0 obs=%b exp=0", {if0.busy, if0.out_valid, if0.msg_end, if0.ch_grant, if0.ch_ready, if0.out_data});
    end
    rst = 1'b0;

    // Round robin with all requests held.
    do_frame(0, 1, 1'b0, 4'b1111, 1'b0, 1'b0, -1);
    do_frame(1, 1, 1'b0, 4'b1111, 1'b0, 1'b0, -1);
    do_frame(2, 1, 1'b0, 4'b1111, 1'b0, 1'b0, -1);
    do_frame(3, 1, 1'b0, 4'b1111, 1'b0, 1'b0, -1);
    do_frame(0, 1, 1'b0, 4'b1111, 1'b0, 1'b0, -1);
    ch_req = '0;
    @(posedge clk); #1;

    // Basic frame with request dropped and length changed mid-frame.
    do_frame(0, 3, 1'b0, 4'b0001, 1'b1, 1'b0, -1);
    // Checksum overflow.
    do_frame(1, 2, 1'b0, 4'b0010, 1'b0, 1'b1, -1);
    // Long frame with ready toggling and valid gaps.
    do_frame(2, 16'h0102, 1'b1, 4'b0100, 1'b0, 1'b0, -1);
    // Reset in the middle of the payload, then a normal frame.
    do_frame(3, 5, 1'b0, 4'b1000, 1'b0, 1'b0, 2);
    do_frame(0, 3, 1'b0, 4'b0001, 1'b0, 1'b0, -1);
    ch_req = '0;
    @(posedge clk); #1;

    // Build without checksum.
    tgt = 1'b0;
    do_frame(0, 0, 1'b0, 4'b0001, 1'b0, 1'b0, -1);
    do_frame(1, 2, 1'b0, 4'b0010, 1'b0, 1'b0, -1);
    ch_req = '0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
